// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage: FSM encodings, reset PC default,
// bubble instruction and a saturating counter helper.
package fetch_stage_pkg;

    localparam logic [0:0]  ST_BOOT          = 1'b0;
    localparam logic [0:0]  ST_RUN           = 1'b1;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;
    localparam logic [31:0] NOP_INSTR        = 32'h0;
    localparam logic [31:0] CNT_MAX          = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == CNT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_stage_next_pc_calc.sv
// Combinational next-PC selection: sequential PC+4 or word-aligned branch
// target BranchPC + (BusImm << 2), all arithmetic modulo 2^64.
module next_pc_calc
    import fetch_stage_pkg::*;
(
    input  logic [63:0] pc,
    input  logic        redirect,
    input  logic [63:0] branch_pc,
    input  logic [63:0] bus_imm,
    output logic [63:0] next_pc
);

    logic [63:0] target_raw;
    logic [63:0] target_aligned;
    logic [63:0] pc_plus4;

    // Offset bits shifted past bit 63 are simply lost, matching 64-bit wrap.
    assign target_raw     = branch_pc + (bus_imm << 2);
    assign target_aligned = target_raw & ~64'h3;
    assign pc_plus4       = pc + 64'd4;
    assign next_pc        = redirect ? target_aligned : pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with BOOT/RUN FSM, PC register and IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [63:0] BranchPC,
    input  logic [63:0] BusImm,
    output logic [63:0] IMemAddr,
    input  logic [31:0] IMemData,
    output logic [31:0] InstrOut,
    output logic [63:0] PCOut,
    output logic        ValidOut
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] FlushCount
`endif
);

    logic [0:0]  state_reg;
    logic [63:0] pc_reg;
    logic [63:0] pc_next;
    logic [31:0] instr_reg;
    logic [63:0] pc_out_reg;
    logic        valid_reg;
    logic        fetch_load;

    next_pc_calc u_next_pc_calc (
        .pc        (pc_reg),
        .redirect  (Redirect),
        .branch_pc (BranchPC),
        .bus_imm   (BusImm),
        .next_pc   (pc_next)
    );

    // A normal fetch happens only in RUN, with no stall and no redirect.
    assign fetch_load = (state_reg == ST_RUN) && !Stall && !Redirect;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_reg  <= ST_BOOT;
            pc_reg     <= RESET_PC;
            instr_reg  <= NOP_INSTR;
            pc_out_reg <= 64'h0;
            valid_reg  <= 1'b0;
        end else if (Redirect) begin
            state_reg  <= ST_RUN;
            pc_reg     <= pc_next;
            instr_reg  <= NOP_INSTR;
            pc_out_reg <= 64'h0;
            valid_reg  <= 1'b0;
        end else if (state_reg == ST_BOOT) begin
            state_reg <= ST_RUN;
        end else if (fetch_load) begin
            pc_reg     <= pc_next;
            instr_reg  <= IMemData;
            pc_out_reg <= pc_reg;
            valid_reg  <= 1'b1;
        end
    end

    assign IMemAddr = pc_reg;
    assign InstrOut = instr_reg;
    assign PCOut    = pc_out_reg;
    assign ValidOut = valid_reg;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_reg;
    logic [31:0] flush_cnt_reg;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            fetch_cnt_reg <= 32'h0;
            flush_cnt_reg <= 32'h0;
        end else begin
            if (fetch_load) begin
                fetch_cnt_reg <= sat_inc(fetch_cnt_reg);
            end
            if (Redirect) begin
                flush_cnt_reg <= sat_inc(flush_cnt_reg);
            end
        end
    end

    assign FetchCount = fetch_cnt_reg;
    assign FlushCount = flush_cnt_reg;
`endif

endmodule
